pair_controller: RTL and testbench
==================================

PAIR_CONTROLLER -- requirements
Module: pair_controller

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles WAIT holds for a matcher verdict before a forced miss.
REQ-002 Parameter PAIRS, default 18: pairs on a full 6x6 board.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 pick  input  1  one-cycle pulse, player selects the card under the cursor.
REQ-006 cursor  input  6  card index, row*6+col; valid range 0..35.
REQ-007 ms  input  1  matcher success verdict.
REQ-008 mf  input  1  matcher failure verdict.
REQ-009 sel_bus  output  36  registered; one bit per selected card, drives matcher sel_bus.
REQ-010 hidden_bus  output  36  registered; one bit per removed card, drives matcher and board.
REQ-011 pairs_left  output  5  registered; pairs still on the board.
REQ-012 misses  output  8  registered; failed attempts, saturating.
REQ-013 busy  output  1  high in states WAIT and HOLD.
REQ-014 game_over  output  1  high in state DONE only.

Function
REQ-015 The block SHALL implement states IDLE, ONE, WAIT, HOLD, DONE; all outputs change only on the rising clk edge, one cycle after the causing input.
REQ-016 A pick SHALL be valid only if cursor <= 35 and hidden_bus[cursor] = 0; invalid picks are ignored in every state.
REQ-017 IDLE: a valid pick SHALL set sel_bus[cursor] and enter ONE.
REQ-018 ONE: a valid pick on the already-selected index SHALL clear that bit and return to IDLE (deselect).
REQ-019 ONE: a valid pick on a different index SHALL set that bit, clear the timeout counter, and enter WAIT; sel_bus then has exactly two bits set.
REQ-020 WAIT, HOLD, DONE: all picks SHALL be ignored; sel_bus SHALL stay constant throughout WAIT.
REQ-021 WAIT with ms = 1: hidden_bus SHALL become hidden_bus OR sel_bus, sel_bus SHALL clear to 0, pairs_left SHALL decrement by 1, enter HOLD.
REQ-022 WAIT with mf = 1 and ms = 0: sel_bus SHALL clear to 0, misses SHALL increment (holding at 255), hidden_bus unchanged, enter HOLD.
REQ-023 ms and mf high in the same WAIT cycle: ms SHALL take priority.
REQ-024 WAIT timeout counter (width clog2(TIMEOUT)) SHALL increment each WAIT cycle; on reaching TIMEOUT-1 without ms/mf the block SHALL act as REQ-022 (forced miss).
REQ-025 HOLD: the block SHALL remain until ms = 0 and mf = 0 in the same cycle (minimum one cycle), then enter DONE if pairs_left = 0, else IDLE.
REQ-026 ms or mf asserted outside WAIT SHALL be ignored.
REQ-027 DONE: game_over = 1; outputs frozen; exit only via rst.
REQ-028 pairs_left SHALL never underflow; a decrement at 0 is suppressed (cannot occur in legal operation).

Reset
REQ-029 rst SHALL win over every other input in the same cycle, including mid-WAIT.
REQ-030 On rst: state IDLE, sel_bus = 0, hidden_bus = 0, pairs_left = PAIRS, misses = 0, busy = 0, game_over = 0, timeout counter = 0.

Verification
REQ-031 Reset, pick 3, pick 9, ms pulse one cycle later -> sel_bus = 0, hidden_bus bits 3 and 9 set, pairs_left = 17, busy low after HOLD, state IDLE.
REQ-032 Pick 4, pick 4 -> sel_bus = 0 after second pick; pick 36 -> ignored, sel_bus = 0; pick hidden index -> ignored.
REQ-033 Pick 0, pick 1, mf pulse -> sel_bus = 0, hidden_bus unchanged, misses = 1; repeat 300 times -> misses = 255.
REQ-034 Pick 0, pick 1, no verdict -> forced miss after exactly TIMEOUT WAIT cycles, misses increments, HOLD then IDLE.
REQ-035 ms and mf together in WAIT -> treated as success; ms held high 3 cycles -> HOLD lasts 3 cycles, no double decrement.
REQ-036 Clear all 18 pairs via ms -> pairs_left = 0, game_over = 1, picks ignored; rst mid-WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pair_controller.sv
// pair_controller: turn sequencer for a 6x6 memory/pairs game.
// Tracks the one or two cards the player has picked and which cards are
// already removed. It waits for the external matcher's verdict, with a
// timeout, and counts the pairs left and the failed attempts.

module pair_controller #(
    parameter int TIMEOUT = 64,
    parameter int PAIRS   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pick,
    input  logic [5:0]  cursor,
    input  logic        ms,
    input  logic        mf,
    output logic [35:0] sel_bus,
    output logic [35:0] hidden_bus,
    output logic [4:0]  pairs_left,
    output logic [7:0]  misses,
    output logic        busy,
    output logic        game_over
);

    // A degenerate TIMEOUT of 1 still needs a 1-bit counter.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ONE,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t         state;
    logic [TW-1:0]  tmo_cnt;
    logic [35:0]    pick_mask;
    logic           pick_ok;

    // One-hot mask of the card under the cursor and the pick-validity test.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_mask = '0;
        for (int i = 0; i < 36; i++) begin
            pick_mask[i] = (cursor == 6'(i));
        end
        // An out-of-range cursor yields an all-zero mask. The range test
        // still rejects it explicitly.
        pick_ok = pick && (cursor <= 6'd35) && ((hidden_bus & pick_mask) == '0);
    end

    // Game FSM. Every output is a register updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state      <= IDLE;
            sel_bus    <= '0;
            hidden_bus <= '0;
            pairs_left <= 5'(PAIRS);
            misses     <= '0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        sel_bus <= sel_bus | pick_mask;
                        state   <= ONE;
                    end
                end

                ONE: begin
                    if (pick_ok) begin
                        if ((sel_bus & pick_mask) != '0) begin
                            // Picking the same card again deselects it.
                            sel_bus <= sel_bus & ~pick_mask;
                            state   <= IDLE;
                        end else begin
                            sel_bus <= sel_bus | pick_mask;
                            tmo_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (ms) begin
                        // A success verdict wins even if mf is high in the same cycle.
                        hidden_bus <= hidden_bus | sel_bus;
                        sel_bus    <= '0;
                        if (pairs_left != '0) begin
                            pairs_left <= pairs_left - 5'd1;
                        end
                        state <= HOLD;
                    end else if (mf || (tmo_cnt == TW'(TIMEOUT - 1))) begin
                        // An explicit failure and a timeout count the same way.
                        sel_bus <= '0;
                        if (misses != 8'hFF) begin
                            misses <= misses + 8'd1;
                        end
                        state <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    // Wait for the matcher to drop its verdict, so that one
                    // long pulse cannot count twice.
                    if (!ms && !mf) begin
                        busy <= 1'b0;
                        if (pairs_left == '0) begin
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                DONE: begin
                    // Frozen until reset.
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_controller.sv
// Testbench for pair_controller. It uses a directed vector table, hand-written
// corner sequences, and random stimulus checked against a behavioural model.

module tb_pair_controller;

    localparam int TIMEOUT = 64;
    localparam int PAIRS   = 18;

    logic        clk;
    logic        rst;
    logic        pick;
    logic [5:0]  cursor;
    logic        ms;
    logic        mf;
    logic [35:0] sel_bus;
    logic [35:0] hidden_bus;
    logic [4:0]  pairs_left;
    logic [7:0]  misses;
    logic        busy;
    logic        game_over;

    pair_controller #(.TIMEOUT(TIMEOUT), .PAIRS(PAIRS)) dut (
        .clk        (clk),
        .rst        (rst),
        .pick       (pick),
        .cursor     (cursor),
        .ms         (ms),
        .mf         (mf),
        .sel_bus    (sel_bus),
        .hidden_bus (hidden_bus),
        .pairs_left (pairs_left),
        .misses     (misses),
        .busy       (busy),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The game is modelled as a list of chosen cards, a set of removed cards,
    // and a count of WAIT cycles that have elapsed.
    localparam int PH_IDLE = 0, PH_ONE = 1, PH_WAIT = 2, PH_HOLD = 3, PH_DONE = 4;
    int  m_phase;
    int  m_chosen[$];
    bit  m_removed[36];
    int  m_pairs;
    int  m_misses;
    int  m_waited;

    function automatic void model_reset();
        m_phase = PH_IDLE;
        m_chosen.delete();
        foreach (m_removed[i]) m_removed[i] = 1'b0;
        m_pairs  = PAIRS;
        m_misses = 0;
        m_waited = 0;
    endfunction

    function automatic void model_miss();
        m_chosen.delete();
        if (m_misses < 255) m_misses++;
        m_phase = PH_HOLD;
    endfunction

    function automatic void model_step(bit r, bit p, int c, bit s, bit f);
        bit valid;
        if (r) begin
            model_reset();
            return;
        end
        valid = p && (c < 36);
        if (valid) valid = !m_removed[c];
        case (m_phase)
            PH_IDLE: if (valid) begin
                m_chosen.push_back(c);
                m_phase = PH_ONE;
            end
            PH_ONE: if (valid) begin
                if (m_chosen[0] == c) begin
                    m_chosen.delete();
                    m_phase = PH_IDLE;
                end else begin
                    m_chosen.push_back(c);
                    m_waited = 0;
                    m_phase  = PH_WAIT;
                end
            end
            PH_WAIT: begin
                m_waited++;
                if (s) begin
                    foreach (m_chosen[i]) m_removed[m_chosen[i]] = 1'b1;
                    m_chosen.delete();
                    if (m_pairs > 0) m_pairs--;
                    m_phase = PH_HOLD;
                end else if (f || m_waited == TIMEOUT) begin
                    model_miss();
                end
            end
            PH_HOLD: if (!s && !f) m_phase = (m_pairs == 0) ? PH_DONE : PH_IDLE;
            default: ;
        endcase
    endfunction

    function automatic logic [35:0] m_sel_vec();
        logic [35:0] v = '0;
        foreach (m_chosen[i]) v[m_chosen[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [35:0] m_hid_vec();
        logic [35:0] v = '0;
        foreach (m_removed[i]) v[i] = m_removed[i];
        return v;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".sel_bus"},    64'(sel_bus),    64'(m_sel_vec()));
        check({tag, ".hidden_bus"}, 64'(hidden_bus), 64'(m_hid_vec()));
        check({tag, ".pairs_left"}, 64'(pairs_left), 64'(m_pairs));
        check({tag, ".misses"},     64'(misses),     64'(m_misses));
        check({tag, ".busy"},       64'(busy),       64'(m_phase == PH_WAIT || m_phase == PH_HOLD));
        check({tag, ".game_over"},  64'(game_over),  64'(m_phase == PH_DONE));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then settle.
    task automatic drive(input bit r, input bit p, input int c, input bit s, input bit f);
        rst    = r;
        pick   = p;
        cursor = 6'(c);
        ms     = s;
        mf     = f;
        @(posedge clk);
        model_step(r, p, c, s, f);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r;
        bit          p;
        int          c;
        bit          s;
        bit          f;
        logic [35:0] e_sel;
        logic [35:0] e_hid;
        int          e_pairs;
        int          e_misses;
        bit          e_busy;
        bit          e_go;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit p, int c, bit s, bit f,
                                logic [35:0] es, logic [35:0] eh,
                                int ep, int em, bit eb, bit eg);
        vec_t v;
        v.r = r; v.p = p; v.c = c; v.s = s; v.f = f;
        v.e_sel = es; v.e_hid = eh; v.e_pairs = ep; v.e_misses = em;
        v.e_busy = eb; v.e_go = eg;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; pick = 1'b0; cursor = '0; ms = 1'b0; mf = 1'b0;
        model_reset();

        //   rst pick cur ms mf   sel           hidden        pairs miss busy go
        add(1, 0,  0, 0, 0, 36'h0,        36'h0,        18, 0, 0, 0);  // reset state
        add(0, 1,  3, 0, 0, 36'h8,        36'h0,        18, 0, 0, 0);  // first pick
        add(0, 1,  9, 0, 0, 36'h208,      36'h0,        18, 0, 1, 0);  // second pick -> WAIT
        add(0, 0,  0, 1, 0, 36'h0,        36'h208,      17, 0, 1, 0);  // match -> HOLD
        add(0, 0,  0, 0, 0, 36'h0,        36'h208,      17, 0, 0, 0);  // HOLD -> IDLE
        add(0, 1,  4, 0, 0, 36'h10,       36'h208,      17, 0, 0, 0);  // select 4
        add(0, 1,  4, 0, 0, 36'h0,        36'h208,      17, 0, 0, 0);  // deselect 4
        add(0, 1, 36, 0, 0, 36'h0,        36'h208,      17, 0, 0, 0);  // cursor 36 ignored
        add(0, 1, 63, 0, 0, 36'h0,        36'h208,      17, 0, 0, 0);  // cursor 63 ignored
        add(0, 1,  3, 0, 0, 36'h0,        36'h208,      17, 0, 0, 0);  // hidden card ignored
        add(0, 1,  0, 0, 0, 36'h1,        36'h208,      17, 0, 0, 0);  // select 0
        add(0, 1,  9, 0, 0, 36'h1,        36'h208,      17, 0, 0, 0);  // hidden in ONE ignored
        add(0, 1,  1, 0, 0, 36'h3,        36'h208,      17, 0, 1, 0);  // select 1 -> WAIT
        add(0, 1,  5, 0, 1, 36'h0,        36'h208,      17, 1, 1, 0);  // mismatch, pick ignored
        add(0, 0,  0, 0, 1, 36'h0,        36'h208,      17, 1, 1, 0);  // mf still high: HOLD
        add(0, 0,  0, 0, 0, 36'h0,        36'h208,      17, 1, 0, 0);  // -> IDLE
        add(0, 0,  0, 1, 1, 36'h0,        36'h208,      17, 1, 0, 0);  // verdict outside WAIT ignored
        add(0, 1, 35, 0, 0, 36'h8_0000_0000, 36'h208,   17, 1, 0, 0);  // last valid index

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].p, vecs[i].c, vecs[i].s, vecs[i].f);
            check($sformatf("vec%0d.sel_bus", i),    64'(sel_bus),    64'(vecs[i].e_sel));
            check($sformatf("vec%0d.hidden_bus", i), 64'(hidden_bus), 64'(vecs[i].e_hid));
            check($sformatf("vec%0d.pairs_left", i), 64'(pairs_left), 64'(vecs[i].e_pairs));
            check($sformatf("vec%0d.misses", i),     64'(misses),     64'(vecs[i].e_misses));
            check($sformatf("vec%0d.busy", i),       64'(busy),       64'(vecs[i].e_busy));
            check($sformatf("vec%0d.game_over", i),  64'(game_over),  64'(vecs[i].e_go));
        end

        // ---- misses saturate at 255 after 300 failed attempts ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
            if (i == 0) check("miss1.misses", 64'(misses), 64'd1);
            idle_cycle();
        end
        check("miss300.misses", 64'(misses), 64'd255);
        check("miss300.hidden", 64'(hidden_bus), 64'd0);
        compare_model("miss300");

        // ---- forced miss after exactly TIMEOUT WAIT cycles ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            idle_cycle();
            compare_model("tmo_wait");
        end
        check("tmo_pre.sel_bus", 64'(sel_bus), 64'h3);
        check("tmo_pre.misses",  64'(misses),  64'd0);
        idle_cycle();
        check("tmo_hit.sel_bus", 64'(sel_bus), 64'h0);
        check("tmo_hit.misses",  64'(misses),  64'd1);
        check("tmo_hit.busy",    64'(busy),    64'd1);
        idle_cycle();
        check("tmo_idle.busy",   64'(busy),    64'd0);
        compare_model("tmo_idle");

        // ---- ms+mf together: success; ms held 3 cycles -> 3-cycle HOLD ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 6, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 7, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        check("both.hidden", 64'(hidden_bus), 64'hC0);
        check("both.pairs",  64'(pairs_left), 64'd17);
        check("both.misses", 64'(misses),     64'd0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("hold2.busy",  64'(busy),       64'd1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        check("hold3.busy",  64'(busy),       64'd1);
        check("hold3.pairs", 64'(pairs_left), 64'd17);
        idle_cycle();
        check("hold_end.busy", 64'(busy), 64'd0);
        compare_model("hold_end");

        // ---- clear the whole board -> DONE, then everything frozen ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int p = 0; p < PAIRS; p++) begin
            drive(1'b0, 1'b1, 2 * p, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 2 * p + 1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
            if (p == PAIRS - 1) check("last.game_over_in_hold", 64'(game_over), 64'd0);
            idle_cycle();
        end
        check("done.pairs",     64'(pairs_left), 64'd0);
        check("done.game_over", 64'(game_over),  64'd1);
        check("done.hidden",    64'(hidden_bus), 64'hF_FFFF_FFFF);
        check("done.busy",      64'(busy),       64'd0);
        drive(1'b0, 1'b1, 5, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 40, 1'b0, 1'b1);
        check("done_frozen.sel",   64'(sel_bus),    64'd0);
        check("done_frozen.pairs", 64'(pairs_left), 64'd0);
        check("done_frozen.go",    64'(game_over),  64'd1);
        compare_model("done_frozen");

        // ---- reset wins mid-WAIT ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 10, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 11, 1'b0, 1'b0);
        idle_cycle();
        drive(1'b1, 1'b1, 12, 1'b1, 1'b0);
        check("rst_wait.sel",    64'(sel_bus),    64'd0);
        check("rst_wait.hidden", 64'(hidden_bus), 64'd0);
        check("rst_wait.pairs",  64'(pairs_left), 64'd18);
        check("rst_wait.misses", 64'(misses),     64'd0);
        check("rst_wait.busy",   64'(busy),       64'd0);
        check("rst_wait.go",     64'(game_over),  64'd0);

        // ---- randomized play against the reference model ----
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            bit r, p, s, f;
            int c;
            r = ($urandom_range(0, 599) == 0);
            p = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(36, 63))
                                             : int'($urandom_range(0, 35));
            s = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 7) == 0);
            drive(r, p, c, s, f);
            compare_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
